// File: rtl/operand_stack_if.sv
// Command/data bundle between the stack datapath controller and operand_stack.
//   master: drives cmd_valid, cmd, push_data, alu_result; observes stack outputs.
//   slave : operand_stack side; drives operand_a/b, tos, count, empty, full, err, err_sticky.
interface operand_stack_if #(
  parameter int unsigned DATA_SIZE = 11,
  parameter int unsigned ADDR_SIZE = 4
);
  logic                 cmd_valid;
  logic [2:0]           cmd;
  logic [DATA_SIZE-1:0] push_data;
  logic [DATA_SIZE-1:0] alu_result;
  logic [DATA_SIZE-1:0] operand_a;
  logic [DATA_SIZE-1:0] operand_b;
  logic [DATA_SIZE-1:0] tos;
  logic [ADDR_SIZE:0]   count;
  logic                 empty;
  logic                 full;
  logic                 err;
  logic                 err_sticky;

  modport master (
    output cmd_valid, cmd, push_data, alu_result,
    input  operand_a, operand_b, tos, count, empty, full, err, err_sticky
  );

  modport slave (
    input  cmd_valid, cmd, push_data, alu_result,
    output operand_a, operand_b, tos, count, empty, full, err, err_sticky
  );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack feeding the ALU. One command per clock:
// NOP, PUSH, POP, BINOP, UNOP, DUP, SWAP, CLR. Overflow/underflow reject the command,
// leave state untouched and raise a one-cycle err plus err_sticky.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (priority over any command)
//   bus_io : operand_stack_if slave modport (command inputs, ALU operands, status)
module operand_stack #(
  parameter int unsigned DATA_SIZE = 11,
  parameter int unsigned ADDR_SIZE = 4
) (
  input logic             clk,
  input logic             reset,
  operand_stack_if.slave  bus_io
);

  localparam int unsigned Depth = 2 ** ADDR_SIZE;
  localparam int unsigned CntW  = ADDR_SIZE + 1;

  typedef logic [CntW-1:0]      cnt_t;
  typedef logic [DATA_SIZE-1:0] data_t;
  typedef logic [ADDR_SIZE-1:0] idx_t;

  localparam logic [2:0] CmdNop   = 3'd0;
  localparam logic [2:0] CmdPush  = 3'd1;
  localparam logic [2:0] CmdPop   = 3'd2;
  localparam logic [2:0] CmdBinop = 3'd3;
  localparam logic [2:0] CmdUnop  = 3'd4;
  localparam logic [2:0] CmdDup   = 3'd5;
  localparam logic [2:0] CmdSwap  = 3'd6;
  localparam logic [2:0] CmdClr   = 3'd7;

  data_t mem_q [Depth];
  cnt_t  count_q, count_d;
  logic  err_q, err_d;
  logic  sticky_q, sticky_d;

  cnt_t  cnt_m1, cnt_m2;
  idx_t  idx_free, idx_top, idx_nos;
  logic  has1, has2, is_full;
  data_t tos_val, nos_val;
  logic  illegal;

  // Two write ports so SWAP can exchange TOS and NOS in a single cycle.
  logic  wr0_en, wr1_en;
  idx_t  wr0_idx, wr1_idx;
  data_t wr0_data, wr1_data;

  assign cnt_m1   = count_q - cnt_t'(1);
  assign cnt_m2   = count_q - cnt_t'(2);
  assign idx_free = count_q[ADDR_SIZE-1:0];
  assign idx_top  = cnt_m1[ADDR_SIZE-1:0];
  assign idx_nos  = cnt_m2[ADDR_SIZE-1:0];

  assign has1    = (count_q != cnt_t'(0));
  assign has2    = (count_q >= cnt_t'(2));
  assign is_full = (count_q == cnt_t'(Depth));

  // Missing entries read as zero.
  assign tos_val = has1 ? mem_q[idx_top] : '0;
  assign nos_val = has2 ? mem_q[idx_nos] : '0;

  // B is always TOS so that A-B = NOS-TOS; a unary op acts on A, so A switches to TOS.
  assign bus_io.operand_b  = tos_val;
  assign bus_io.operand_a  = (bus_io.cmd_valid && (bus_io.cmd == CmdUnop)) ? tos_val : nos_val;
  assign bus_io.tos        = tos_val;
  assign bus_io.count      = count_q;
  assign bus_io.empty      = !has1;
  assign bus_io.full       = is_full;
  assign bus_io.err        = err_q;
  assign bus_io.err_sticky = sticky_q;

  always_comb begin
    count_d  = count_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    illegal  = 1'b0;
    wr0_en   = 1'b0;
    wr0_idx  = idx_free;
    wr0_data = bus_io.push_data;
    wr1_en   = 1'b0;
    wr1_idx  = idx_nos;
    wr1_data = tos_val;

    if (bus_io.cmd_valid) begin
      case (bus_io.cmd)
        CmdNop: ;
        CmdPush: begin
          if (is_full) begin
            illegal = 1'b1;
          end else begin
            wr0_en  = 1'b1;
            count_d = count_q + cnt_t'(1);
          end
        end
        CmdPop: begin
          if (!has1) illegal = 1'b1;
          else       count_d = cnt_m1;
        end
        CmdBinop: begin
          if (!has2) begin
            illegal = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = idx_nos;
            wr0_data = bus_io.alu_result;
            count_d  = cnt_m1;
          end
        end
        CmdUnop: begin
          if (!has1) begin
            illegal = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = idx_top;
            wr0_data = bus_io.alu_result;
          end
        end
        CmdDup: begin
          if (!has1 || is_full) begin
            illegal = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_data = tos_val;
            count_d  = count_q + cnt_t'(1);
          end
        end
        CmdSwap: begin
          if (!has2) begin
            illegal = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = idx_top;
            wr0_data = nos_val;
            wr1_en   = 1'b1;
            wr1_idx  = idx_nos;
            wr1_data = tos_val;
          end
        end
        CmdClr: begin
          count_d  = '0;
          sticky_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (illegal) begin
      err_d    = 1'b1;
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  // Entry storage has no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr0_en) mem_q[wr0_idx] <= wr0_data;
      if (wr1_en) mem_q[wr1_idx] <= wr1_data;
    end
  end

endmodule
